// File: rtl/cmos_pixel_pack.sv
// CMOS byte-stream packer: discards a settling period of frames after reset, then packs
// byte pairs into RGB565 words with frame/line markers and a sticky line-format error.
module cmos_pixel_pack #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = 1280
) (
    input  logic        sck,
    input  logic        rst_n,
    input  logic        cmos_href_delay,
    input  logic        cmos_vsync_delay,
    input  logic [7:0]  cmos_data_delay,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_ready,
    output logic [11:0] line_cnt,
    output logic        line_err
);

    localparam int              SKIP_W    = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [11:0]     H_PIX     = 12'(H_PIXELS);

    typedef enum logic {
        S_SKIP   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SKIP_W-1:0]   r_skip_cnt;

    logic                r_vsync_d;
    logic                r_href_d;
    logic                r_phase;
    logic                r_drop_line;
    logic                r_first_pix;
    logic [7:0]          r_hi;
    logic [11:0]         r_pix_cnt;

    logic                r_pixel_valid_p1;
    logic [15:0]         r_pixel_data_p1;
    logic                r_frame_start_p1;
    logic                r_line_end_p1;
    logic [11:0]         r_line_cnt_p1;
    logic                r_line_err_p1;

    logic                w_vs_rise;
    logic                w_hr_fall;
    logic                w_active;
    logic                w_enter;
    logic                w_accept;
    logic                w_pix_emit;
    logic                w_line_done;
    logic                w_frame_edge;
    logic                w_frame_ready;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign w_vs_rise   = cmos_vsync_delay & ~r_vsync_d;
    assign w_hr_fall   = ~cmos_href_delay & r_href_d;
    assign w_active    = (r_state == S_ACTIVE);
    assign w_enter     = (r_state == S_SKIP) && w_vs_rise && (r_skip_cnt == SKIP_LAST);
    // A line already under way when vsync rises is never resumed, so no partial line leaks in.
    assign w_accept    = w_active && cmos_href_delay && !cmos_vsync_delay && !r_drop_line;
    assign w_pix_emit  = w_accept && r_phase;
    assign w_line_done = w_active && w_hr_fall && !r_drop_line;
    assign w_frame_edge = w_vs_rise && (w_active || w_enter);

    // Stage 0: input edge detect
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= cmos_vsync_delay;
            r_href_d  <= cmos_href_delay;
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SKIP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SKIP:   if (w_enter) w_state_nxt = S_ACTIVE;
            S_ACTIVE: w_state_nxt = S_ACTIVE;
            default:  w_state_nxt = S_SKIP;
        endcase
    end

    always_comb begin
        w_frame_ready = 1'b0;
        if (r_state == S_ACTIVE) w_frame_ready = 1'b1;
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= '0;
        end else if ((r_state == S_SKIP) && w_vs_rise && !w_enter) begin
            r_skip_cnt <= r_skip_cnt + SKIP_ONE;
        end
    end

    // Stage 0: byte phase, high-byte latch and per-line bookkeeping
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_hi        <= 8'd0;
            r_drop_line <= 1'b0;
            r_first_pix <= 1'b0;
            r_pix_cnt   <= 12'd0;
        end else begin
            if (!cmos_href_delay || cmos_vsync_delay) begin
                r_phase <= 1'b0;
            end else if (w_accept) begin
                r_phase <= ~r_phase;
            end

            if (w_accept && !r_phase) begin
                r_hi <= cmos_data_delay;
            end

            if (!cmos_href_delay) begin
                r_drop_line <= 1'b0;
            end else if (cmos_vsync_delay) begin
                r_drop_line <= 1'b1;
            end

            if (w_frame_edge) begin
                r_first_pix <= 1'b1;
            end else if (w_pix_emit) begin
                r_first_pix <= 1'b0;
            end

            if (w_hr_fall || (w_active && w_vs_rise)) begin
                r_pix_cnt <= 12'd0;
            end else if (w_pix_emit) begin
                r_pix_cnt <= sat_inc12(r_pix_cnt);
            end
        end
    end

    // Stage 1: registered pixel strobe and line/frame markers
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_valid_p1 <= 1'b0;
            r_pixel_data_p1  <= 16'd0;
            r_frame_start_p1 <= 1'b0;
            r_line_end_p1    <= 1'b0;
            r_line_cnt_p1    <= 12'd0;
            r_line_err_p1    <= 1'b0;
        end else begin
            r_pixel_valid_p1 <= w_pix_emit;
            r_frame_start_p1 <= w_pix_emit && r_first_pix;
            if (w_pix_emit) begin
                r_pixel_data_p1 <= {r_hi, cmos_data_delay};
            end

            r_line_end_p1 <= w_line_done;
            // A line closing on the same edge as vsync still reports, but the new frame counts from 0.
            if (w_active && w_vs_rise) begin
                r_line_cnt_p1 <= 12'd0;
            end else if (w_line_done) begin
                r_line_cnt_p1 <= r_line_cnt_p1 + 12'd1;
            end

            if (w_line_done && (r_phase || (r_pix_cnt != H_PIX))) begin
                r_line_err_p1 <= 1'b1;
            end
        end
    end

    assign pixel_valid = r_pixel_valid_p1;
    assign pixel_data  = r_pixel_data_p1;
    assign frame_start = r_frame_start_p1;
    assign line_end    = r_line_end_p1;
    assign frame_ready = w_frame_ready;
    assign line_cnt    = r_line_cnt_p1;
    assign line_err    = r_line_err_p1;

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Directed bench for cmos_pixel_pack with a short skip period and 4-pixel lines.
module tb_cmos_pixel_pack;

    localparam int SKIP = 2;
    localparam int HPIX = 4;

    logic        sck   = 1'b0;
    logic        rst_n = 1'b0;
    logic        href  = 1'b0;
    logic        vsync = 1'b0;
    logic [7:0]  data  = 8'd0;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic        frame_start;
    logic        line_end;
    logic        frame_ready;
    logic [11:0] line_cnt;
    logic        line_err;

    int n_chk = 0;
    int n_fail = 0;
    int v_cnt = 0;
    int le_cnt = 0;
    int fs_cnt = 0;
    int skip_viol = 0;
    int b_v, b_le, b_fs, b_sv;

    cmos_pixel_pack #(
        .SKIP_FRAMES(SKIP),
        .H_PIXELS   (HPIX)
    ) dut (
        .sck              (sck),
        .rst_n            (rst_n),
        .cmos_href_delay  (href),
        .cmos_vsync_delay (vsync),
        .cmos_data_delay  (data),
        .pixel_valid      (pixel_valid),
        .pixel_data       (pixel_data),
        .frame_start      (frame_start),
        .line_end         (line_end),
        .frame_ready      (frame_ready),
        .line_cnt         (line_cnt),
        .line_err         (line_err)
    );

    always #5 sck = ~sck;

    always @(negedge sck) begin
        if (rst_n) begin
            if (pixel_valid) v_cnt <= v_cnt + 1;
            if (line_end)    le_cnt <= le_cnt + 1;
            if (frame_start) fs_cnt <= fs_cnt + 1;
            if (!frame_ready && (pixel_valid || line_end || frame_start || line_err ||
                                 line_cnt != 12'd0 || pixel_data != 16'd0))
                skip_viol <= skip_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic [7:0] d);
        href  = h;
        vsync = v;
        data  = d;
        @(posedge sck);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 8'd0);
        idle(2);
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] base);
        for (int i = 0; i < nbytes; i++) drive(1'b1, 1'b0, base + 8'(i));
        idle(3);
    endtask

    task automatic send_frame(input int nlines);
        vs_pulse();
        for (int l = 0; l < nlines; l++) send_line(2 * HPIX, 8'(16 * l));
    endtask

    initial begin
        repeat (3) @(posedge sck);
        #1;
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_data", 32'(pixel_data), 32'd0);
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_lcnt", 32'(line_cnt), 32'd0);
        chk("rst_err", 32'(line_err), 32'd0);
        chk("rst_lend", 32'(line_end), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Skip period, then one captured 4-line frame
        b_v = v_cnt; b_sv = skip_viol;
        send_frame(4);
        send_frame(4);
        chk("ready_skip", 32'(frame_ready), 32'd0);
        chk("skip_no_pix", 32'(v_cnt - b_v), 32'd0);
        drive(1'b0, 1'b1, 8'd0);
        chk("ready_rise", 32'(frame_ready), 32'd1);
        drive(1'b0, 1'b1, 8'd0);
        idle(2);
        b_v = v_cnt; b_le = le_cnt; b_fs = fs_cnt;
        for (int l = 0; l < 4; l++) send_line(2 * HPIX, 8'(32 * l));
        chk("frm_pix", 32'(v_cnt - b_v), 32'd16);
        chk("frm_lend", 32'(le_cnt - b_le), 32'd4);
        chk("frm_fs", 32'(fs_cnt - b_fs), 32'd1);
        chk("frm_lcnt", 32'(line_cnt), 32'd4);
        chk("frm_err", 32'(line_err), 32'd0);
        chk("skip_quiet", 32'(skip_viol - b_sv), 32'd0);

        // Packing order, latency and frame_start placement
        drive(1'b0, 1'b1, 8'd0);
        chk("vs_lcnt_clr", 32'(line_cnt), 32'd0);
        drive(1'b0, 1'b1, 8'd0);
        idle(2);
        drive(1'b1, 1'b0, 8'hAB);
        chk("pk_v0", 32'(pixel_valid), 32'd0);
        drive(1'b1, 1'b0, 8'hCD);
        chk("pk_v1", 32'(pixel_valid), 32'd1);
        chk("pk_d1", 32'(pixel_data), 32'hABCD);
        chk("pk_fs1", 32'(frame_start), 32'd1);
        drive(1'b1, 1'b0, 8'h12);
        chk("pk_v2", 32'(pixel_valid), 32'd0);
        chk("pk_hold", 32'(pixel_data), 32'hABCD);
        chk("pk_fs2", 32'(frame_start), 32'd0);
        drive(1'b1, 1'b0, 8'h34);
        chk("pk_v3", 32'(pixel_valid), 32'd1);
        chk("pk_d3", 32'(pixel_data), 32'h1234);
        chk("pk_fs3", 32'(frame_start), 32'd0);
        drive(1'b1, 1'b0, 8'h56);
        drive(1'b1, 1'b0, 8'h78);
        drive(1'b1, 1'b0, 8'h9A);
        drive(1'b1, 1'b0, 8'hBC);
        drive(1'b0, 1'b0, 8'd0);
        chk("pk_lend", 32'(line_end), 32'd1);
        chk("pk_lcnt", 32'(line_cnt), 32'd1);
        drive(1'b0, 1'b0, 8'd0);
        chk("pk_lend_off", 32'(line_end), 32'd0);
        chk("pk_err", 32'(line_err), 32'd0);

        // vsync rising mid-line discards the partial line
        b_v = v_cnt; b_le = le_cnt;
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b1, 1'b1, 8'h05);
        drive(1'b1, 1'b1, 8'h06);
        for (int i = 7; i <= 10; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'd0);
        chk("mid_no_lend", 32'(line_end), 32'd0);
        idle(2);
        chk("mid_pix", 32'(v_cnt - b_v), 32'd2);
        chk("mid_lend_cnt", 32'(le_cnt - b_le), 32'd0);
        chk("mid_lcnt", 32'(line_cnt), 32'd0);
        chk("mid_err", 32'(line_err), 32'd0);
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        chk("mid_fs", 32'(frame_start), 32'd1);
        chk("mid_data", 32'(pixel_data), 32'h1122);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'd0);
        chk("mid_next_lend", 32'(line_end), 32'd1);
        chk("mid_next_lcnt", 32'(line_cnt), 32'd1);

        // Line end and frame boundary on the same edge
        for (int i = 0; i < 2 * HPIX; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b1, 8'd0);
        chk("sim_lend", 32'(line_end), 32'd1);
        chk("sim_lcnt", 32'(line_cnt), 32'd0);
        chk("sim_err", 32'(line_err), 32'd0);
        drive(1'b0, 1'b1, 8'd0);
        idle(2);

        // Odd byte count: dangling byte dropped, sticky error
        b_v = v_cnt;
        send_line(2 * HPIX + 1, 8'h40);
        chk("odd_pix", 32'(v_cnt - b_v), 32'(HPIX));
        chk("odd_err", 32'(line_err), 32'd1);
        send_frame(2);
        chk("err_sticky", 32'(line_err), 32'd1);

        // Asynchronous reset in the middle of a line
        drive(1'b1, 1'b0, 8'h5A);
        drive(1'b1, 1'b0, 8'hA5);
        drive(1'b1, 1'b0, 8'h77);
        chk("pre_rst_data", 32'(pixel_data), 32'h5AA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(pixel_data), 32'd0);
        chk("arst_lcnt", 32'(line_cnt), 32'd0);
        chk("arst_ready", 32'(frame_ready), 32'd0);
        chk("arst_err", 32'(line_err), 32'd0);
        href = 1'b0;
        vsync = 1'b0;
        @(posedge sck);
        #1;
        rst_n = 1'b1;
        b_v = v_cnt; b_sv = skip_viol;
        send_frame(2);
        send_frame(2);
        chk("rskip_ready", 32'(frame_ready), 32'd0);
        chk("rskip_pix", 32'(v_cnt - b_v), 32'd0);
        chk("rskip_quiet", 32'(skip_viol - b_sv), 32'd0);
        drive(1'b0, 1'b1, 8'd0);
        chk("rready_rise", 32'(frame_ready), 32'd1);
        drive(1'b0, 1'b1, 8'd0);
        idle(2);

        // Good line, then a line one pixel short
        b_le = le_cnt;
        send_line(2 * HPIX, 8'h60);
        chk("good_err", 32'(line_err), 32'd0);
        chk("good_lend", 32'(le_cnt - b_le), 32'd1);
        send_line(2 * (HPIX - 1), 8'h70);
        chk("short_lend", 32'(le_cnt - b_le), 32'd2);
        chk("short_err", 32'(line_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
